// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: resolves dmem waits, imem waits, EX redirects, a redirect that
// arrives during an imem wait, and load-use hazards with a fixed priority.
// It also flags memory stalls that run too long.
//
// Optional feature macro: PIPE_FWD_CNT_EN adds stall_cycles, a saturating
// count of pc_stall cycles since reset.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   id_rs, id_rt              source registers of the ID instruction
//   id_rs_used, id_rt_used    ID instruction reads id_rs / id_rt
//   ex_mem_read, ex_rd        EX holds a load that writes ex_rd
//   redirect                  EX resolved a taken branch/jump
//   imem_stall, dmem_stall    instruction / data memory not done
//   pc_stall                  hold PC (a redirect load overrides it)
//   if_id_stall, if_id_flush  IF/ID hold / load NOP 16'h0FFF
//   id_ex_bubble              ID/EX loads a bubble
//   back_stall                freeze EX/MEM and MEM/WB
//   redir_pend                registered: redirect waiting on imem completion
//   err_timeout               registered, sticky memory-stall timeout
//   stall_cycles              (PIPE_FWD_CNT_EN only) pc_stall cycle count
module pipe_hazard_ctrl #(
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             redirect,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             back_stall,
  output logic             redir_pend,
  output logic             err_timeout
`ifdef PIPE_FWD_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, IWAIT} state_t;

  state_t      state, state_nxt;
  logic        redir_pend_nxt;
  logic [15:0] stall_cnt;
  logic        load_use;
  logic        mem_stall;

  assign load_use  = ex_mem_read &&
                     ((id_rs_used && (id_rs == ex_rd)) ||
                      (id_rt_used && (id_rt == ex_rd)));
  assign mem_stall = imem_stall | dmem_stall;

  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    back_stall     = 1'b0;
    state_nxt      = RUN;
    redir_pend_nxt = redir_pend;
    if (!rst) begin
      // Fill IF/ID with NOP while held in reset.
      if_id_flush    = 1'b1;
      redir_pend_nxt = 1'b0;
    end else if (dmem_stall) begin
      // Whole machine frozen; a redirect is held by its source in EX.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      back_stall  = 1'b1;
      state_nxt   = DWAIT;
    end else if (imem_stall) begin
      pc_stall    = 1'b1;
      if_id_flush = 1'b1;
      if (redirect) begin
        // PC takes the target now, but the fetch in flight is wrong-path.
        id_ex_bubble   = 1'b1;
        redir_pend_nxt = 1'b1;
      end
      state_nxt = IWAIT;
    end else if (redirect) begin
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      // This flush also covers any wrong-path fetch still pending.
      redir_pend_nxt = 1'b0;
    end else if (redir_pend && (state != RUN)) begin
      // Memory wait just ended: the delivered instruction is wrong-path.
      // A dmem wait after the imem wait keeps the release pending.
      if_id_flush    = 1'b1;
      redir_pend_nxt = 1'b0;
    end else if (load_use) begin
      // One cycle suffices: the load moves on to MEM at this edge.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      redir_pend  <= 1'b0;
      err_timeout <= 1'b0;
      stall_cnt   <= 16'd0;
    end else begin
      state      <= state_nxt;
      redir_pend <= redir_pend_nxt;
      if (mem_stall) begin
        if (stall_cnt != 16'hFFFF)
          stall_cnt <= stall_cnt + 16'd1;
        if (stall_cnt == 16'(TIMEOUT - 1))
          err_timeout <= 1'b1;
      end else begin
        stall_cnt <= 16'd0;
      end
    end
  end

`ifdef PIPE_FWD_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)
      stall_cycles <= 16'd0;
    else if (pc_stall && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule
